// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-stream image loader writing 16-bit words to memory with XOR checksum
module mem_loader #(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [15:0]           mem_write_data,
    output logic                  mem_write_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR
    } state_t;

    localparam int          CW       = ADDR_WIDTH + 1;
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [7:0]            data_hi_q, data_hi_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;

    logic        accept;
    logic [15:0] len_full;
    logic        start_ok;

    assign accept   = rx_valid & rx_ready;
    assign len_full = {len_hi_q, rx_data};
    assign start_ok = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERROR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            len_hi_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            data_hi_q <= '0;
            csum_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            data_hi_q <= data_hi_d;
            csum_q    <= csum_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: if (start_ok) state_d = LEN_HI;
            LEN_HI:  if (accept) state_d = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if ({1'b0, len_full} > CAPACITY) state_d = ERROR;
                    else if (len_full == 16'd0)      state_d = CHECK;
                    else                             state_d = DATA_HI;
                end
            end
            DATA_HI: if (accept) state_d = DATA_LO;
            DATA_LO: if (accept) state_d = WRITE;
            WRITE:   state_d = ((idx_q + CW'(1)) < len_q) ? DATA_HI : CHECK;
            CHECK: begin
                if (accept) state_d = (rx_data == csum_q) ? DONE : ERROR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: the checksum folds in every length and data byte, never the checksum byte itself.
    always_comb begin
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        idx_d     = idx_q;
        data_hi_d = data_hi_q;
        csum_d    = csum_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if (start_ok) begin
            idx_d  = '0;
            csum_d = '0;
        end
        if (accept && state_q != CHECK) csum_d = csum_q ^ rx_data;
        case (state_q)
            LEN_HI:  if (accept) len_hi_d = rx_data;
            LEN_LO:  if (accept) len_d = len_full[CW-1:0];
            DATA_HI: if (accept) data_hi_d = rx_data;
            DATA_LO: begin
                if (accept) begin
                    addr_d  = idx_q[ADDR_WIDTH-1:0];
                    wdata_d = {data_hi_q, rx_data};
                end
            end
            WRITE:   idx_d = idx_q + CW'(1);
            default: ;
        endcase
    end

    always_comb begin
        rx_ready         = 1'b0;
        mem_write_enable = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;
        error            = 1'b0;
        case (state_q)
            IDLE:                            busy = 1'b0;
            DONE:    begin busy = 1'b0; done  = 1'b1; end
            ERROR:   begin busy = 1'b0; error = 1'b1; end
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: rx_ready = 1'b1;
            WRITE:                           mem_write_enable = 1'b1;
            default: ;
        endcase
    end

    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;

endmodule
